pea_scheduler: RTL and testbench

PEA_SCHEDULER -- requirements
Module: pea_scheduler

---
 rtl/pea_scheduler.sv | 175 +++++++++++++++++
 tb/tb_pea_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pea_scheduler.sv
// PEA actor firing scheduler: sequences CHECK/FIRE/WAIT around the enable and FC handshakes.
// Optional FC watchdog is built only when PEA_SCHED_TIMEOUT_EN is defined.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | not scheduling; waits for run (one arming edge after reset)
//   S_CHECK | presenting next_instr, re-sampling enable every cycle
//   S_FIRE  | invoke high for this single cycle
//   S_WAIT  | waiting for an FC rising edge (or one latched during FIRE)
//   S_HALT  | error stop; only clear leaves it
module pea_scheduler #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clear,
    input  logic             enable,
    input  logic             FC,
    input  logic [1:0]       next_mode_in,
    output logic             invoke,
    output logic [1:0]       next_instr,
    output logic             busy,
    output logic [CNT_W-1:0] fire_count,
    output logic             err,
    output logic [1:0]       err_code
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_FIRE  = 3'd2,
        S_WAIT  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_INVALID = 2'b11;
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MODE     = 2'b01;

    // The watchdog limit must be at least one cycle.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    end

    state_t           r_state;
    logic             r_invoke;
    logic [1:0]       r_next_instr;
    logic             r_busy;
    logic [CNT_W-1:0] r_fire_count;
    logic             r_err;
    logic [1:0]       r_err_code;
    logic             r_fc_q;
    logic             r_fc_pend;
    logic             r_armed;

    logic w_fc_rise;
    logic w_done;

    assign w_fc_rise = FC & ~r_fc_q;
    assign w_done    = w_fc_rise | r_fc_pend;

`ifdef PEA_SCHED_TIMEOUT_EN
    localparam int         WD_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    logic [WD_W-1:0] r_wdog;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_invoke     <= 1'b0;
            r_next_instr <= 2'b00;
            r_busy       <= 1'b0;
            r_fire_count <= '0;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_fc_q       <= 1'b0;
            r_fc_pend    <= 1'b0;
            r_armed      <= 1'b0;
`ifdef PEA_SCHED_TIMEOUT_EN
            r_wdog       <= '0;
`endif
        end else begin
            r_fc_q  <= FC;
            r_armed <= 1'b1;
            if (clear) begin
                // Abandons any firing in flight; fire_count and FC history survive.
                r_state      <= S_IDLE;
                r_invoke     <= 1'b0;
                r_next_instr <= 2'b00;
                r_busy       <= 1'b0;
                r_err        <= 1'b0;
                r_err_code   <= ERR_NONE;
                r_fc_pend    <= 1'b0;
`ifdef PEA_SCHED_TIMEOUT_EN
                r_wdog       <= '0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (run && r_armed) begin
                            r_state <= S_CHECK;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_CHECK: begin
                        if (!run) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else if (enable) begin
                            r_state  <= S_FIRE;
                            r_invoke <= 1'b1;
                        end
                    end
                    S_FIRE: begin
                        r_state   <= S_WAIT;
                        r_invoke  <= 1'b0;
                        r_fc_pend <= w_fc_rise;
`ifdef PEA_SCHED_TIMEOUT_EN
                        r_wdog    <= '0;
`endif
                    end
                    S_WAIT: begin
                        if (w_done) begin
                            r_fc_pend    <= 1'b0;
                            r_fire_count <= r_fire_count + CNT_W'(1);
                            if (next_mode_in == MODE_INVALID) begin
                                r_state    <= S_HALT;
                                r_busy     <= 1'b0;
                                r_err      <= 1'b1;
                                r_err_code <= ERR_MODE;
                            end else begin
                                r_next_instr <= next_mode_in;
                                if (run) begin
                                    r_state <= S_CHECK;
                                end else begin
                                    r_state <= S_IDLE;
                                    r_busy  <= 1'b0;
                                end
                            end
                        end
`ifdef PEA_SCHED_TIMEOUT_EN
                        else if (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                            r_state    <= S_HALT;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                            r_err_code <= ERR_TIMEOUT;
                        end else begin
                            r_wdog <= r_wdog + WD_W'(1);
                        end
`endif
                    end
                    S_HALT: begin
                        r_invoke <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_invoke <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign invoke     = r_invoke;
    assign next_instr = r_next_instr;
    assign busy       = r_busy;
    assign fire_count = r_fire_count;
    assign err        = r_err;
    assign err_code   = r_err_code;

endmodule

// File: tb/tb_pea_scheduler.sv
// Self-checking bench for pea_scheduler: directed scenarios plus randomized firings
// checked against a completion-level reference model.
module tb_pea_scheduler;

    localparam int CNT_W = 3;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run = 1'b0;
    logic             clear = 1'b0;
    logic             enable = 1'b0;
    logic             FC = 1'b0;
    logic [1:0]       next_mode_in = 2'b00;
    logic             invoke;
    logic [1:0]       next_instr;
    logic             busy;
    logic [CNT_W-1:0] fire_count;
    logic             err;
    logic [1:0]       err_code;

    int         checks = 0;
    int         failures = 0;
    int         exp_count = 0;
    logic [1:0] exp_instr = 2'b00;

    pea_scheduler #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .run(run), .clear(clear), .enable(enable), .FC(FC),
        .next_mode_in(next_mode_in), .invoke(invoke), .next_instr(next_instr),
        .busy(busy), .fire_count(fire_count), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_invoke"}, 32'(invoke), 0);
        chk({tag, "_instr"}, 32'(next_instr), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_count"}, 32'(fire_count), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_code"}, 32'(err_code), 0);
    endtask

    // Starts from CHECK with FC low; fc_delay 0 raises FC during FIRE.
    task automatic do_firing(input logic [1:0] mode, input int en_delay, input int fc_delay,
                             input bit drop_run);
        enable = 1'b0;
        for (int i = 0; i < en_delay; i++) begin
            tick();
            chk("check_no_invoke", 32'(invoke), 0);
            chk("check_busy", 32'(busy), 1);
        end
        enable = 1'b1;
        tick();
        chk("invoke_on", 32'(invoke), 1);
        chk("fire_busy", 32'(busy), 1);
        enable = 1'($urandom_range(0, 1));
        next_mode_in = mode;
        if (fc_delay == 0) FC = 1'b1;
        tick();
        chk("invoke_off", 32'(invoke), 0);
        chk("wait_busy0", 32'(busy), 1);
        if (drop_run) run = 1'b0;
        for (int i = 1; i < fc_delay; i++) begin
            tick();
            chk("wait_busy", 32'(busy), 1);
            chk("wait_count", 32'(fire_count), 32'(exp_count));
            chk("wait_invoke", 32'(invoke), 0);
        end
        FC = 1'b1;
        tick();
        exp_count = (exp_count + 1) % CNT_MOD;
        if (mode != 2'b11) exp_instr = mode;
        chk("done_count", 32'(fire_count), 32'(exp_count));
        chk("done_instr", 32'(next_instr), 32'(exp_instr));
        chk("done_invoke", 32'(invoke), 0);
        if (mode == 2'b11) begin
            chk("bad_err", 32'(err), 1);
            chk("bad_code", 32'(err_code), 1);
            chk("bad_busy", 32'(busy), 0);
        end else begin
            chk("done_err", 32'(err), 0);
            chk("done_busy", 32'(busy), drop_run ? 0 : 1);
        end
        FC = 1'b0;
        enable = 1'b0;
        if (drop_run && mode != 2'b11) begin
            run = 1'b1;
            tick();
            chk("rearm_busy", 32'(busy), 1);
        end
    endtask

    initial begin
        // Asynchronous reset with no clock edge involved
        #2 rst = 1'b0;
        #1 chk_reset_values("reset");

        // First CHECK only on the second edge with run high
        run = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk("arm_edge1_busy", 32'(busy), 0);
        tick();
        chk("arm_edge2_busy", 32'(busy), 1);

        // Three firings, FC five cycles after each invoke
        do_firing(2'b01, 0, 5, 1'b0);
        do_firing(2'b00, 0, 5, 1'b0);
        do_firing(2'b10, 0, 5, 1'b0);
        chk("seq_count3", 32'(fire_count), 3);
        chk("seq_instr", 32'(next_instr), 2);

        // Long enable-low stretch in CHECK
        do_firing(2'b01, 20, 3, 1'b0);

        // FC already high when the firing starts: no completion until a fresh edge
        FC = 1'b1;
        tick();
        chk("fc_high_check_busy", 32'(busy), 1);
        enable = 1'b1;
        tick();
        chk("fc_high_invoke", 32'(invoke), 1);
        enable = 1'b0;
        next_mode_in = 2'b10;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("fc_high_wait_busy", 32'(busy), 1);
            chk("fc_high_wait_count", 32'(fire_count), 32'(exp_count));
        end
        FC = 1'b0;
        tick();
        chk("fc_low_wait_count", 32'(fire_count), 32'(exp_count));
        FC = 1'b1;
        tick();
        exp_count = (exp_count + 1) % CNT_MOD;
        exp_instr = 2'b10;
        chk("fc_fresh_count", 32'(fire_count), 32'(exp_count));
        chk("fc_fresh_instr", 32'(next_instr), 32'(exp_instr));
        FC = 1'b0;

        // Randomized firings; the count wraps through 2^CNT_W
        for (int n = 0; n < 14; n++) begin
            do_firing(2'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0));
        end

        // Invalid mode at completion halts with sticky error
        do_firing(2'b11, 1, 2, 1'b0);
        run = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            FC = ~FC;
            tick();
            chk("halt_invoke", 32'(invoke), 0);
            chk("halt_busy", 32'(busy), 0);
            chk("halt_err", 32'(err), 1);
            chk("halt_code", 32'(err_code), 1);
        end
        FC = 1'b0;
        enable = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_instr = 2'b00;
        chk("clr_err", 32'(err), 0);
        chk("clr_code", 32'(err_code), 0);
        chk("clr_instr", 32'(next_instr), 0);
        chk("clr_busy", 32'(busy), 0);
        chk("clr_count", 32'(fire_count), 32'(exp_count));
        tick();
        chk("clr_to_check", 32'(busy), 1);

        // FC never arrives
        tick();
        enable = 1'b1;
        tick();
        chk("to_invoke", 32'(invoke), 1);
        enable = 1'b0;
`ifdef PEA_SCHED_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("to_wait_err", 32'(err), 0);
            chk("to_wait_busy", 32'(busy), 1);
        end
        tick();
        chk("to_err", 32'(err), 1);
        chk("to_code", 32'(err_code), 2);
        chk("to_busy", 32'(busy), 0);
        chk("to_count", 32'(fire_count), 32'(exp_count));
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("nowd_busy", 32'(busy), 1);
            chk("nowd_err", 32'(err), 0);
        end
`endif
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_instr = 2'b00;
        chk("abandon_busy", 32'(busy), 0);
        chk("abandon_count", 32'(fire_count), 32'(exp_count));
        chk("abandon_code", 32'(err_code), 0);

        // Reach fire_count=7, then reset asynchronously mid-WAIT
        rst = 1'b0;
        #1;
        tick();
        rst = 1'b1;
        exp_count = 0;
        exp_instr = 2'b00;
        tick();
        tick();
        chk("rearm_after_rst", 32'(busy), 1);
        for (int n = 0; n < 7; n++) begin
            do_firing(2'($urandom_range(0, 2)), 0, int'($urandom_range(1, 3)), 1'b0);
        end
        chk("count_seven", 32'(fire_count), 7);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        tick();
        chk("midwait_busy", 32'(busy), 1);
        #2 rst = 1'b0;
        #1 chk_reset_values("async_rst");
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
